// File: rtl/membus_ram_responder_pkg.sv
// Shared constants and types for the Membus RAM responder.
package membus_ram_responder_pkg;

  localparam int unsigned ADDR_W = 32;

  typedef enum logic {
    S_IDLE,
    S_READ_WAIT
  } rstate_t;

  // Number of byte lanes in an XLEN-bit word.
  function automatic int unsigned byte_count(input int unsigned xlen);
    return xlen / 8;
  endfunction

  // Address bits that select a byte within a word.
  function automatic int unsigned off_width(input int unsigned xlen);
    return $clog2(xlen / 8);
  endfunction

endpackage

// File: rtl/membus_ram_responder_ram_byte_we.sv
// DEPTH x XLEN single-port RAM with per-byte write enable and a synchronous read port.
module membus_ram_responder_ram_byte_we
  import membus_ram_responder_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 4096
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [XLEN-1:0]          wdata,
  input  logic [XLEN/8-1:0]        wmask,
  output logic [XLEN-1:0]          rdata
);

  localparam int unsigned BYTES = byte_count(XLEN);

  logic [XLEN-1:0] mem [DEPTH];

  // Byte-masked write and registered read; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < BYTES; i++) begin
        if (wmask[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/membus_ram_responder.sv
// Membus slave-side RAM responder: byte-masked writes complete at the handshake,
// reads return after READ_LATENCY cycles with at most one read outstanding.
// Optional feature: define RAM_RESPONDER_STALL_EN to insert LFSR-driven ready stalls.
module membus_ram_responder
  import membus_ram_responder_pkg::*;
#(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned DEPTH        = 4096,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_valid,
  output logic              bus_ready,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_wen,
  input  logic [XLEN-1:0]   bus_wdata,
  input  logic [XLEN/8-1:0] bus_wmask,
  output logic              bus_rvalid,
  output logic [XLEN-1:0]   bus_rdata
);

  localparam int unsigned OFF_W = off_width(XLEN);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  rstate_t          state;
  logic [CNT_W-1:0] cnt;
  logic             rvalid_q;
  logic             stall;
  logic             fire;
  logic             wr_fire;
  logic             rd_fire;
  logic [IDX_W-1:0] idx;
  logic [XLEN-1:0]  ram_rdata;
  logic             unused_addr_bits;

  // Word index: drop byte offset, wrap modulo DEPTH.
  assign idx              = bus_addr[OFF_W +: IDX_W];
  assign unused_addr_bits = ^{bus_addr[ADDR_W-1:OFF_W+IDX_W], bus_addr[OFF_W-1:0]};

  assign bus_ready = rst && (state == S_IDLE) && !stall;
  assign fire      = bus_valid && bus_ready;
  assign wr_fire   = fire && bus_wen;
  assign rd_fire   = fire && !bus_wen;

  assign bus_rvalid = rvalid_q;
  assign bus_rdata  = rvalid_q ? ram_rdata : '0;

`ifdef RAM_RESPONDER_STALL_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR (taps 16,14,13,11) free-running to generate pseudo-random stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Read-wait FSM with latency down-counter; rvalid is raised on the last wait cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      rvalid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          rvalid_q <= 1'b0;
          if (rd_fire) begin
            state    <= S_READ_WAIT;
            cnt      <= CNT_W'(READ_LATENCY - 1);
            rvalid_q <= (READ_LATENCY == 1);
          end
        end
        S_READ_WAIT: begin
          if (cnt == '0) begin
            state    <= S_IDLE;
            rvalid_q <= 1'b0;
          end else begin
            cnt      <= cnt - CNT_W'(1);
            rvalid_q <= (cnt == CNT_W'(1));
          end
        end
        default: begin
          state    <= S_IDLE;
          cnt      <= '0;
          rvalid_q <= 1'b0;
        end
      endcase
    end
  end

  membus_ram_responder_ram_byte_we #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_fire),
    .re    (rd_fire),
    .idx   (idx),
    .wdata (bus_wdata),
    .wmask (bus_wmask),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_membus_ram_responder.sv
// Directed bench for membus_ram_responder: one instance at READ_LATENCY=1 (a_*)
// and one at READ_LATENCY=3 (b_*), sharing clock and reset.
module tb_membus_ram_responder;

  logic        clk;
  logic        rst;

  logic        a_valid, a_ready, a_wen, a_rvalid;
  logic [31:0] a_addr;
  logic [63:0] a_wdata, a_rdata;
  logic [7:0]  a_wmask;

  logic        b_valid, b_ready, b_wen, b_rvalid;
  logic [31:0] b_addr;
  logic [63:0] b_wdata, b_rdata;
  logic [7:0]  b_wmask;

  int checks;
  int errors;

  logic [63:0] bb_data [4] = '{64'hC0DE_0000_0000_0000, 64'hC0DE_0000_0000_0001,
                               64'hC0DE_0000_0000_0002, 64'hC0DE_0000_0000_0003};

  membus_ram_responder #(.XLEN(64), .DEPTH(4096), .READ_LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .bus_valid(a_valid), .bus_ready(a_ready), .bus_addr(a_addr),
    .bus_wen(a_wen), .bus_wdata(a_wdata), .bus_wmask(a_wmask),
    .bus_rvalid(a_rvalid), .bus_rdata(a_rdata)
  );

  membus_ram_responder #(.XLEN(64), .DEPTH(4096), .READ_LATENCY(3)) u_lat3 (
    .clk(clk), .rst(rst), .bus_valid(b_valid), .bus_ready(b_ready), .bus_addr(b_addr),
    .bus_wen(b_wen), .bus_wdata(b_wdata), .bus_wmask(b_wmask),
    .bus_rvalid(b_rvalid), .bus_rdata(b_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Helpers are entered and return just after a negedge.
  task automatic a_write(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] mask);
    int n = 0;
    a_valid = 1'b1; a_wen = 1'b1; a_addr = addr; a_wdata = data; a_wmask = mask;
    while (!a_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL a_write_timeout: ready=%0b after %0d cycles, required 1", a_ready, n);
    end
    @(negedge clk);
    a_valid = 1'b0; a_wen = 1'b0;
  endtask

  task automatic a_read(input logic [31:0] addr, output logic [63:0] data, output int lat);
    int n = 0;
    a_valid = 1'b1; a_wen = 1'b0; a_addr = addr; a_wmask = 8'h00;
    while (!a_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    a_valid = 1'b0;
    lat = 1;
    while (!a_rvalid && lat < 20) begin @(negedge clk); lat++; end
    if (n >= 20 || lat >= 20) begin
      checks++; errors++;
      $display("FAIL a_read_timeout: accept_wait=%0d latency=%0d, required <20", n, lat);
    end
    data = a_rdata;
  endtask

  task automatic b_read(input logic [31:0] addr, output logic [63:0] data, output int lat);
    int n = 0;
    b_valid = 1'b1; b_wen = 1'b0; b_addr = addr; b_wmask = 8'h00;
    while (!b_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    b_valid = 1'b0;
    lat = 1;
    while (!b_rvalid && lat < 20) begin @(negedge clk); lat++; end
    if (n >= 20 || lat >= 20) begin
      checks++; errors++;
      $display("FAIL b_read_timeout: accept_wait=%0d latency=%0d, required <20", n, lat);
    end
    data = b_rdata;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    a_valid = 0; a_wen = 0; a_addr = 0; a_wdata = 0; a_wmask = 0;
    b_valid = 0; b_wen = 0; b_addr = 0; b_wdata = 0; b_wmask = 0;
    repeat (2) @(negedge clk);
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %0b, required 0", a_ready); end
    checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %0b, required 0", a_rvalid); end
    checks++; if (a_rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h, required 0", a_rdata); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL release_ready_a: got %0b, required 1", a_ready); end
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL release_ready_b: got %0b, required 1", b_ready); end
    checks++; if (a_rvalid !== 1'b0 || a_rdata !== 64'h0) begin
      errors++; $display("FAIL release_idle_out: rvalid=%0b rdata=%h, required 0/0", a_rvalid, a_rdata);
    end
  endtask

  task automatic test_full_write_read;
    logic [63:0] d; int lat;
    a_write(32'h10, 64'h1122334455667788, 8'hFF);
    a_read(32'h10, d, lat);
    checks++; if (d !== 64'h1122334455667788) begin errors++; $display("FAIL full_rdata: got %h, required 1122334455667788", d); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL full_latency: got %0d, required 1", lat); end
    @(negedge clk);
    checks++; if (a_rvalid !== 1'b0 || a_rdata !== 64'h0 || a_ready !== 1'b1) begin
      errors++; $display("FAIL after_rvalid: rvalid=%0b rdata=%h ready=%0b, required 0/0/1", a_rvalid, a_rdata, a_ready);
    end
  endtask

  task automatic test_partial_write;
    logic [63:0] d; int lat;
    a_write(32'h10, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    a_read(32'h10, d, lat);
    checks++; if (d !== 64'h11223344AAAAAAAA) begin errors++; $display("FAIL partial_rdata: got %h, required 11223344aaaaaaaa", d); end
    @(negedge clk);
    a_read(32'h14, d, lat);
    checks++; if (d !== 64'h11223344AAAAAAAA) begin errors++; $display("FAIL offset_ignored: got %h, required 11223344aaaaaaaa", d); end
    @(negedge clk);
  endtask

  task automatic test_addr_wrap;
    logic [63:0] d; int lat;
    a_write(32'h8000, 64'hDEADBEEFCAFEF00D, 8'hFF);
    a_read(32'h0, d, lat);
    checks++; if (d !== 64'hDEADBEEFCAFEF00D) begin errors++; $display("FAIL wrap_rdata: got %h, required deadbeefcafef00d", d); end
    @(negedge clk);
    a_read(32'h10, d, lat);
    checks++; if (d !== 64'h11223344AAAAAAAA) begin errors++; $display("FAIL wrap_neighbour: got %h, required 11223344aaaaaaaa", d); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic       exp_ready  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       exp_rvalid [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int lat;
    for (int i = 0; i < 4; i++) begin
      b_valid = 1'b1; b_wen = 1'b1; b_addr = 32'(8 * i); b_wdata = bb_data[i]; b_wmask = 8'hFF;
      checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL b2b_write_ready[%0d]: got %0b, required 1", i, b_ready); end
      @(negedge clk);
    end
    b_wen = 1'b0; b_addr = 32'h8; b_wmask = 8'h00;
    for (int k = 0; k < 5; k++) begin
      checks++; if (b_ready !== exp_ready[k] || b_rvalid !== exp_rvalid[k]) begin
        errors++; $display("FAIL held_read_cycle%0d: ready=%0b rvalid=%0b, required %0b/%0b",
                           k, b_ready, b_rvalid, exp_ready[k], exp_rvalid[k]);
      end
      if (k == 3) begin
        checks++; if (b_rdata !== bb_data[1]) begin errors++; $display("FAIL held_read_rdata: got %h, required %h", b_rdata, bb_data[1]); end
      end
      @(negedge clk);
    end
    b_valid = 1'b0;
    lat = 1;
    while (!b_rvalid && lat < 20) begin @(negedge clk); lat++; end
    checks++; if (lat !== 3) begin errors++; $display("FAIL refire_latency: got %0d, required 3", lat); end
    checks++; if (b_rdata !== bb_data[1]) begin errors++; $display("FAIL refire_rdata: got %h, required %h", b_rdata, bb_data[1]); end
    @(negedge clk);
  endtask

  task automatic test_reset_during_wait;
    logic [63:0] d; int lat; bit saw;
    repeat (2) @(negedge clk);
    a_valid = 1'b1; a_wen = 1'b0; a_addr = 32'h10;
    b_valid = 1'b1; b_wen = 1'b0; b_addr = 32'h10;
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
      errors++; $display("FAIL rdw_ready: a=%0b b=%0b, required 1/1", a_ready, b_ready);
    end
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    checks++; if (a_rvalid !== 1'b1) begin errors++; $display("FAIL rdw_a_rvalid: got %0b, required 1", a_rvalid); end
    #2 rst = 1'b0;
    #1;
    checks++; if (a_rvalid !== 1'b0 || a_rdata !== 64'h0) begin
      errors++; $display("FAIL midcycle_reset_out: rvalid=%0b rdata=%h, required 0/0", a_rvalid, a_rdata);
    end
    checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      errors++; $display("FAIL midcycle_reset_ready: a=%0b b=%0b, required 0/0", a_ready, b_ready);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    saw = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (b_rvalid !== 1'b0) saw = 1'b1;
    end
    checks++; if (saw) begin errors++; $display("FAIL discarded_read: rvalid seen=1, required 0"); end
    b_read(32'h10, d, lat);
    checks++; if (d !== bb_data[2]) begin errors++; $display("FAIL post_reset_b_rdata: got %h, required %h", d, bb_data[2]); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL post_reset_b_latency: got %0d, required 3", lat); end
    a_read(32'h10, d, lat);
    checks++; if (d !== 64'h11223344AAAAAAAA) begin errors++; $display("FAIL post_reset_a_rdata: got %h, required 11223344aaaaaaaa", d); end
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_full_write_read();
    test_partial_write();
    test_addr_wrap();
    test_back_to_back();
    test_reset_during_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
